hex_entry: RTL and testbench

- Board input front-end for the processor: the input-side counterpart of the seven-segment display path.
- Collects a 16-bit value typed by the user, one hex nibble at a time. Nibble comes from slide switches; each press of the Enter pushbutton commits it.
- Debounces and edge-detects the raw active-low KEY inputs.
- Presents the assembled value to the processor with a Valid/Ack handshake.

---
 rtl/hex_entry.sv | 135 +++++++++++++
 tb/tb_hex_entry.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_entry.sv
// Board hex-entry front end: synchronizes and debounces the Enter/Clear keys,
// shifts switch nibbles into a value and offers it to the processor via Valid/Ack.
//
// state   | meaning
// COLLECT | accepting nibbles, Count < NIBBLES, Valid low
// FULL    | value complete and held, waiting for Ack (or Clear)
module hex_entry #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NIBBLES         = 4
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic [3:0]           Nibble,
    input  logic                 EnterKey,
    input  logic                 ClearKey,
    input  logic                 Ack,
    output logic [4*NIBBLES-1:0] Value,
    output logic [2:0]           Count,
    output logic                 Valid,
    output logic                 EnterPulse
);

    localparam int               W          = 4 * NIBBLES;
    localparam int               CNT_W      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       COUNT_FULL = 3'(NIBBLES);
    localparam int               ENTER      = 0;
    localparam int               CLEAR      = 1;

    typedef enum logic {COLLECT, FULL} state_t;

    logic [1:0]       key_s1_q, key_s2_q;
    logic [1:0]       db_q, db_d, db_del_q;
    logic [1:0]       ev_q, ev_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [3:0]       nib_s1_q, nib_s2_q;

    state_t           state_q, state_d;
    logic [W-1:0]     value_q, value_d;
    logic [2:0]       count_q, count_d;
    logic             valid_q, valid_d;
    logic             pulse_q, pulse_d;

    // Keys are active-low: a press is the debounced level falling 1->0.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            db_d[k]  = db_q[k];
            cnt_d[k] = '0;
            if (key_s2_q[k] != db_q[k]) begin
                if (cnt_q[k] == CNT_LAST) begin
                    db_d[k] = key_s2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
        ev_d = db_del_q & ~db_q;
    end

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        count_d = count_q;
        valid_d = valid_q;
        pulse_d = 1'b0;
        if (ev_q[CLEAR]) begin
            state_d = COLLECT;
            value_d = '0;
            count_d = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (ev_q[ENTER]) begin
                        value_d = {value_q[W-5:0], nib_s2_q};
                        count_d = count_q + 3'd1;
                        pulse_d = 1'b1;
                        if (count_q + 3'd1 == COUNT_FULL) begin
                            valid_d = 1'b1;
                            state_d = FULL;
                        end
                    end
                end
                FULL: begin
                    if (Ack) begin
                        state_d = COLLECT;
                        value_d = '0;
                        count_d = '0;
                        valid_d = 1'b0;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            key_s1_q <= '1;
            key_s2_q <= '1;
            db_q     <= '1;
            db_del_q <= '1;
            ev_q     <= '0;
            for (int k = 0; k < 2; k++) cnt_q[k] <= '0;
            nib_s1_q <= '0;
            nib_s2_q <= '0;
            state_q  <= COLLECT;
            value_q  <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            key_s1_q <= {ClearKey, EnterKey};
            key_s2_q <= key_s1_q;
            db_q     <= db_d;
            db_del_q <= db_q;
            ev_q     <= ev_d;
            for (int k = 0; k < 2; k++) cnt_q[k] <= cnt_d[k];
            nib_s1_q <= Nibble;
            nib_s2_q <= nib_s1_q;
            state_q  <= state_d;
            value_q  <= value_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            pulse_q  <= pulse_d;
        end
    end

    assign Value      = value_q;
    assign Count      = count_q;
    assign Valid      = valid_q;
    assign EnterPulse = pulse_q;

endmodule

// File: tb/tb_hex_entry.sv
// Bench for hex_entry with DEBOUNCE_CYCLES=4: directed scenarios plus random
// key/nibble/ack traffic, all compared against a window-based behavioural model.
module tb_hex_entry;

    localparam int D = 4;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  nib  = 4'h0;
    logic        ekey = 1'b1;
    logic        ckey = 1'b1;
    logic        ack  = 1'b0;
    logic [15:0] Value;
    logic [2:0]  Count;
    logic        Valid;
    logic        EnterPulse;

    int checks   = 0;
    int failures = 0;

    hex_entry #(.DEBOUNCE_CYCLES(D), .NIBBLES(4)) dut (
        .Clock(clk), .Resetn(rstn), .Nibble(nib), .EnterKey(ekey), .ClearKey(ckey),
        .Ack(ack), .Value(Value), .Count(Count), .Valid(Valid), .EnterPulse(EnterPulse)
    );

    always #5 clk = ~clk;

    // Model: a key level is accepted once the last D synchronized samples all
    // disagree with the accepted level; the press event follows one cycle after.
    bit          m_raw  [2][$];
    logic [3:0]  m_nraw [$];
    bit          m_hist [2][$];
    bit          m_db   [2];
    bit          m_fell [2];
    bit          m_ev   [2];
    logic [15:0] m_value;
    logic [2:0]  m_count;
    bit          m_valid, m_pulse;
    logic [20:0] lm_dut, lm_mod;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_raw[k] = {1'b1, 1'b1};
            m_hist[k].delete();
            m_db[k] = 1'b1; m_fell[k] = 1'b0; m_ev[k] = 1'b0;
        end
        m_nraw  = {4'h0, 4'h0};
        m_value = '0; m_count = '0; m_valid = 1'b0; m_pulse = 1'b0;
    endfunction

    function automatic void model_edge();
        logic [3:0] nib_s;
        bit         fell_now [2];
        if (!rstn) begin
            model_reset();
            return;
        end
        nib_s = m_nraw[0];
        void'(m_nraw.pop_front());
        m_nraw.push_back(nib);
        m_pulse = 1'b0;
        if (m_ev[1]) begin
            m_value = '0; m_count = '0; m_valid = 1'b0;
        end else if (m_valid) begin
            if (ack) begin m_value = '0; m_count = '0; m_valid = 1'b0; end
        end else if (m_ev[0]) begin
            m_value = {m_value[11:0], nib_s};
            m_count = m_count + 3'd1;
            m_pulse = 1'b1;
            if (m_count == 3'd4) m_valid = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            bit s, keyin, all_diff;
            s     = m_raw[k][0];
            keyin = (k == 0) ? ekey : ckey;
            void'(m_raw[k].pop_front());
            m_raw[k].push_back(keyin);
            m_hist[k].push_back(s);
            if (m_hist[k].size() > D) void'(m_hist[k].pop_front());
            fell_now[k] = 1'b0;
            if (m_hist[k].size() == D) begin
                all_diff = 1'b1;
                foreach (m_hist[k][j]) if (m_hist[k][j] == m_db[k]) all_diff = 1'b0;
                if (all_diff) begin
                    m_db[k] = s;
                    m_hist[k].delete();
                    fell_now[k] = !s;
                end
            end
            m_ev[k]   = m_fell[k];
            m_fell[k] = fell_now[k];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Advances n cycles, tallying EnterPulse strobes and model disagreements.
    task automatic hold(input int n, inout int pulses, inout int mism);
        for (int i = 0; i < n; i++) begin
            tick();
            if (EnterPulse === 1'b1) pulses++;
            if ({Value, Count, Valid, EnterPulse} !== {m_value, m_count, m_valid, m_pulse}) begin
                mism++;
                lm_dut = {Value, Count, Valid, EnterPulse};
                lm_mod = {m_value, m_count, m_valid, m_pulse};
            end
        end
    endtask

    task automatic do_reset();
        int p = 0, m = 0;
        ekey = 1'b1; ckey = 1'b1; ack = 1'b0;
        rstn = 1'b0; tick(); rstn = 1'b1;
        hold(12, p, m);
    endtask

    task automatic enter_digit(input logic [3:0] d, inout int pulses, inout int mism);
        nib = d;
        hold(3, pulses, mism);
        ekey = 1'b0; hold(10, pulses, mism);
        ekey = 1'b1; hold(10, pulses, mism);
    endtask

    task automatic test_reset();
        int p = 0, m = 0, first = -1;
        ekey = 1'b0; ckey = 1'b0; nib = 4'h9;
        rstn = 1'b0; tick(); rstn = 1'b1;
        checks++;
        if ({Value, Count, Valid, EnterPulse} !== 21'h0) begin
            failures++; $display("FAIL reset_outputs got=%h want=0", {Value, Count, Valid, EnterPulse});
        end
        hold(20, p, m);
        checks++;
        if (p != 0 || Value !== 16'h0 || Count !== 3'd0) begin
            failures++; $display("FAIL both_held pulses=%0d value=%h count=%0d want 0/0/0", p, Value, Count);
        end
        ckey = 1'b1;
        rstn = 1'b0; tick(); rstn = 1'b1;
        p = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (EnterPulse === 1'b1) begin p++; if (first < 0) first = i; end
            if ({Value, Count, Valid, EnterPulse} !== {m_value, m_count, m_valid, m_pulse}) m++;
        end
        checks++;
        if (first != 8 || p != 1) begin
            failures++; $display("FAIL held_enter_event first=%0d pulses=%0d want 8/1", first, p);
        end
        checks++;
        if (Value !== 16'h0009 || Count !== 3'd1) begin
            failures++; $display("FAIL held_enter_value value=%h count=%0d want 0009/1", Value, Count);
        end
        checks++;
        if (m != 0) begin failures++; $display("FAIL reset_model mism=%0d dut=%h model=%h", m, lm_dut, lm_mod); end
        ekey = 1'b1;
    endtask

    task automatic test_entry();
        int p = 0, m = 0;
        do_reset();
        enter_digit(4'hA, p, m); enter_digit(4'hB, p, m);
        enter_digit(4'hC, p, m); enter_digit(4'hD, p, m);
        checks++;
        if (Value !== 16'hABCD || Count !== 3'd4 || Valid !== 1'b1) begin
            failures++; $display("FAIL entry_value value=%h count=%0d valid=%b want ABCD/4/1", Value, Count, Valid);
        end
        checks++;
        if (p != 4) begin failures++; $display("FAIL entry_pulses got=%0d want 4", p); end
        checks++;
        if (m != 0) begin failures++; $display("FAIL entry_model mism=%0d dut=%h model=%h", m, lm_dut, lm_mod); end
    endtask

    task automatic test_bounce();
        int p = 0, m = 0;
        do_reset();
        nib = 4'h7;
        hold(3, p, m);
        for (int i = 0; i < 10; i++) begin ekey = ~ekey; hold(2, p, m); end
        ekey = 1'b0; hold(15, p, m);
        ekey = 1'b1; hold(10, p, m);
        checks++;
        if (Value !== 16'h0007 || Count !== 3'd1 || p != 1) begin
            failures++; $display("FAIL bounce value=%h count=%0d pulses=%0d want 0007/1/1", Value, Count, p);
        end
        checks++;
        if (m != 0) begin failures++; $display("FAIL bounce_model mism=%0d dut=%h model=%h", m, lm_dut, lm_mod); end
    endtask

    task automatic test_full_ack();
        int p = 0, m = 0;
        do_reset();
        enter_digit(4'hA, p, m); enter_digit(4'hB, p, m);
        enter_digit(4'hC, p, m); enter_digit(4'hD, p, m);
        p = 0;
        enter_digit(4'h5, p, m);
        checks++;
        if (Value !== 16'hABCD || Valid !== 1'b1 || Count !== 3'd4 || p != 0) begin
            failures++; $display("FAIL full_hold value=%h valid=%b count=%0d pulses=%0d want ABCD/1/4/0", Value, Valid, Count, p);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if (Valid !== 1'b0 || Value !== 16'h0 || Count !== 3'd0) begin
            failures++; $display("FAIL ack_clear value=%h valid=%b count=%0d want 0/0/0", Value, Valid, Count);
        end
        hold(5, p, m);
        checks++;
        if (m != 0) begin failures++; $display("FAIL full_model mism=%0d dut=%h model=%h", m, lm_dut, lm_mod); end
    endtask

    task automatic test_clear();
        int p = 0, m = 0;
        do_reset();
        enter_digit(4'h1, p, m); enter_digit(4'h2, p, m);
        checks++;
        if (Value !== 16'h0012 || Count !== 3'd2) begin
            failures++; $display("FAIL pre_clear value=%h count=%0d want 0012/2", Value, Count);
        end
        ckey = 1'b0; hold(10, p, m);
        ckey = 1'b1; hold(10, p, m);
        checks++;
        if (Value !== 16'h0 || Count !== 3'd0) begin
            failures++; $display("FAIL clear value=%h count=%0d want 0/0", Value, Count);
        end
        enter_digit(4'h4, p, m);
        nib = 4'h3; p = 0;
        ekey = 1'b0; ckey = 1'b0; hold(12, p, m);
        ekey = 1'b1; ckey = 1'b1; hold(10, p, m);
        checks++;
        if (Value !== 16'h0 || Count !== 3'd0 || p != 0) begin
            failures++; $display("FAIL clear_vs_enter value=%h count=%0d pulses=%0d want 0/0/0", Value, Count, p);
        end
        checks++;
        if (m != 0) begin failures++; $display("FAIL clear_model mism=%0d dut=%h model=%h", m, lm_dut, lm_mod); end
    endtask

    task automatic test_reset_mid();
        int p = 0, m = 0;
        do_reset();
        enter_digit(4'h6, p, m);
        p = 0;
        ekey = 1'b0; hold(5, p, m);
        ekey = 1'b1; rstn = 1'b0; tick(); rstn = 1'b1;
        hold(15, p, m);
        checks++;
        if (p != 0 || {Value, Count, Valid, EnterPulse} !== 21'h0) begin
            failures++; $display("FAIL reset_mid pulses=%0d outs=%h want 0/0", p, {Value, Count, Valid, EnterPulse});
        end
        ack = 1'b1; tick(); ack = 1'b0;
        hold(3, p, m);
        checks++;
        if ({Value, Count, Valid, EnterPulse} !== 21'h0) begin
            failures++; $display("FAIL ack_idle outs=%h want 0", {Value, Count, Valid, EnterPulse});
        end
        checks++;
        if (m != 0) begin failures++; $display("FAIL reset_mid_model mism=%0d dut=%h model=%h", m, lm_dut, lm_mod); end
    endtask

    task automatic test_random();
        int p = 0, m = 0;
        do_reset();
        for (int seg = 0; seg < 400; seg++) begin
            int len;
            nib  = 4'($urandom);
            ekey = 1'($urandom_range(0, 1));
            ckey = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
            rstn = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            len  = $urandom_range(1, 12);
            for (int j = 0; j < len; j++) begin
                ack = ($urandom_range(0, 5) == 0);
                hold(1, p, m);
                rstn = 1'b1;
            end
            ack = 1'b0;
        end
        checks++;
        if (m != 0) begin failures++; $display("FAIL random_model mism=%0d dut=%h model=%h", m, lm_dut, lm_mod); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_entry();
        test_bounce();
        test_full_ack();
        test_clear();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "bench time limit reached");
    end

endmodule
